// File: rtl/arcade_input.sv
// arcade_input -- registered input front end for arcade cores.
//
// It merges the PS/2 keyboard, USB pads and external (UserIO) pads into one
// control vector per player. It then applies SOCD cleaning, per-button
// autofire, a fixed-length coin pulse and a latched pause toggle.
//
// Ports
//   clk            system clock (clk_sys)
//   reset_n        asynchronous active-low reset
//   ps2_key        [10] toggles per event, [9] pressed, [7:0] scan code
//   joy_usb        USB pads, 16 bits each, allocated in index order
//   joy_ext        external pads, one 16-bit slot per player
//   ext_ena        per player: take joy_ext slot instead of a USB pad
//   autofire_mask  buttons with autofire enabled (shared by all players)
//   joy_out        processed controls, same per-player layout as the inputs
//   pause          latched pause state
//
// Per-pad layout: [0]R [1]L [2]D [3]U [4+b] button b,
// [4+BUTTONS] start, [5+BUTTONS] coin, [6+BUTTONS] pause.
module arcade_input #(
   parameter int unsigned PLAYERS      = 2,
   parameter int unsigned BUTTONS      = 3,
   parameter int unsigned AUTOFIRE_DIV = 4_000_000,
   parameter int unsigned COIN_PULSE   = 1_000_000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [10:0]           ps2_key,
   input  logic [PLAYERS*16-1:0] joy_usb,
   input  logic [PLAYERS*16-1:0] joy_ext,
   input  logic [PLAYERS-1:0]    ext_ena,
   input  logic [BUTTONS-1:0]    autofire_mask,
   output logic [PLAYERS*16-1:0] joy_out,
   output logic                  pause
);

   localparam int unsigned START_BIT = 4 + BUTTONS;
   localparam int unsigned COIN_BIT  = 5 + BUTTONS;
   localparam int unsigned PAUSE_BIT = 6 + BUTTONS;
   localparam logic [15:0] USED_MASK = 16'((32'd1 << (PAUSE_BIT + 1)) - 32'd1);
   localparam int unsigned TW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
   localparam int unsigned CW = $clog2(COIN_PULSE + 1);

   logic [PLAYERS-1:0][15:0] usb_v, ext_v;
   assign usb_v = joy_usb;
   assign ext_v = joy_ext;

   // armed_q/edge_ok_q: ignore the first keyboard sample and the first S1
   // capture after reset, so inputs held through reset never count as events.
   logic tog_q, armed_q, edge_ok_q;
   logic kev;
   assign kev = armed_q & (ps2_key[10] ^ tog_q);

   // ---------------- keyboard decode ----------------
   logic [PLAYERS-1:0][15:0] key_q, key_d;
   logic       khit, kpl, kbtn;
   logic [1:0] kb;
   logic [3:0] kbit;

   always_comb begin
      khit = 1'b1;
      kpl  = 1'b0;
      kbtn = 1'b0;
      kb   = '0;
      kbit = '0;
      case (ps2_key[7:0])
         8'h75: kbit = 4'd3;
         8'h72: kbit = 4'd2;
         8'h6B: kbit = 4'd1;
         8'h74: kbit = 4'd0;
         8'h14: begin kbtn = 1'b1; kb = 2'd0; end
         8'h11: begin kbtn = 1'b1; kb = 2'd1; end
         8'h29: begin kbtn = 1'b1; kb = 2'd2; end
         8'h16: kbit = 4'(START_BIT);
         8'h2E: kbit = 4'(COIN_BIT);
         8'h4D: kbit = 4'(PAUSE_BIT);
         8'h2D: begin kpl = 1'b1; kbit = 4'd3; end
         8'h2B: begin kpl = 1'b1; kbit = 4'd2; end
         8'h23: begin kpl = 1'b1; kbit = 4'd1; end
         8'h34: begin kpl = 1'b1; kbit = 4'd0; end
         8'h1C: begin kpl = 1'b1; kbtn = 1'b1; kb = 2'd0; end
         8'h1B: begin kpl = 1'b1; kbtn = 1'b1; kb = 2'd1; end
         8'h15: begin kpl = 1'b1; kbtn = 1'b1; kb = 2'd2; end
         8'h1E: begin kpl = 1'b1; kbit = 4'(START_BIT); end
         8'h36: begin kpl = 1'b1; kbit = 4'(COIN_BIT); end
         default: khit = 1'b0;
      endcase
      // Button keys are resolved separately so they never alias start/coin
      // when BUTTONS is small.
      if (kbtn) begin
         kbit = 4'd4 + {2'b00, kb};
         if (BUTTONS <= 32'(kb)) khit = 1'b0;
      end
   end

   always_comb begin
      key_d = key_q;
      for (int unsigned p = 0; p < PLAYERS; p++)
         if (kev && khit && (32'(kpl) == p)) key_d[p][kbit] = ps2_key[9];
   end

   // ---------------- source allocation / stage 1 ----------------
   logic [PLAYERS-1:0][15:0] s1_d, s1_q, prev_q;

   always_comb begin : merge
      int unsigned k;
      logic [15:0] src;
      k    = 0;
      src  = '0;
      s1_d = '0;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
         src = '0;
         if (ext_ena[p]) begin
            src = ext_v[p];
         end else begin
            for (int unsigned q = 0; q < PLAYERS; q++)
               if (q == k) src = usb_v[q];
            k = k + 1;
         end
         s1_d[p] = (src & USED_MASK) | key_q[p];
      end
   end

   // ---------------- stage 2 ----------------
   logic [TW-1:0] tick_q, tick_d;
   logic          tick;
   logic [PLAYERS-1:0][BUTTONS-1:0] phase_q, phase_d;
   logic [PLAYERS-1:0][CW-1:0]      coin_q, coin_d;
   logic [PLAYERS-1:0][15:0]        rise, out_d, out_q;
   logic                            pause_q, pause_d;

   assign tick   = (tick_q == TW'(AUTOFIRE_DIV - 1));
   assign tick_d = tick ? '0 : tick_q + TW'(1);

   always_comb begin
      rise    = '0;
      out_d   = '0;
      phase_d = phase_q;
      coin_d  = coin_q;
      pause_d = pause_q;
      for (int unsigned p = 0; p < PLAYERS; p++) begin
         if (edge_ok_q) rise[p] = s1_q[p] & ~prev_q[p];
         out_d[p][0] = s1_q[p][0] & ~s1_q[p][1];
         out_d[p][1] = s1_q[p][1] & ~s1_q[p][0];
         out_d[p][2] = s1_q[p][2] & ~s1_q[p][3];
         out_d[p][3] = s1_q[p][3] & ~s1_q[p][2];
         for (int unsigned b = 0; b < BUTTONS; b++) begin
            // A press wins over a coincident tick: it always starts high.
            if (rise[p][4+b])
               phase_d[p][b] = 1'b1;
            else if (s1_q[p][4+b] && tick)
               phase_d[p][b] = ~phase_q[p][b];
            out_d[p][4+b] = s1_q[p][4+b] & (~autofire_mask[b] | phase_d[p][b]);
         end
         out_d[p][START_BIT] = s1_q[p][START_BIT];
         if (coin_q[p] != '0)
            coin_d[p] = coin_q[p] - CW'(1);
         else if (rise[p][COIN_BIT])
            coin_d[p] = CW'(COIN_PULSE);
         out_d[p][COIN_BIT] = (coin_d[p] != '0);
         // Several players' edges in one cycle still toggle only once.
         if (rise[p][PAUSE_BIT]) pause_d = ~pause_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tog_q     <= 1'b0;
         armed_q   <= 1'b0;
         edge_ok_q <= 1'b0;
         key_q     <= '0;
         s1_q      <= '0;
         prev_q    <= '0;
         tick_q    <= '0;
         phase_q   <= '0;
         coin_q    <= '0;
         out_q     <= '0;
         pause_q   <= 1'b0;
      end else begin
         tog_q     <= ps2_key[10];
         armed_q   <= 1'b1;
         edge_ok_q <= armed_q;
         key_q     <= key_d;
         s1_q      <= s1_d;
         prev_q    <= s1_q;
         tick_q    <= tick_d;
         phase_q   <= phase_d;
         coin_q    <= coin_d;
         out_q     <= out_d;
         pause_q   <= pause_d;
      end
   end

   assign joy_out = out_q;
   assign pause   = pause_q;

   logic unused_ok;
   assign unused_ok = ^{ps2_key[8], rise};

endmodule

// File: tb/tb_arcade_input.sv
// Testbench for arcade_input: directed scenarios plus randomized stimulus
// compared against a cycle-level behavioural model of the control rules.
module tb_arcade_input;
   localparam int unsigned PLAYERS   = 2;
   localparam int unsigned BUTTONS   = 3;
   localparam int unsigned AFD       = 4;
   localparam int unsigned COIN      = 5;
   localparam int unsigned START_BIT = 4 + BUTTONS;
   localparam int unsigned COIN_BIT  = 5 + BUTTONS;
   localparam int unsigned PAUSE_BIT = 6 + BUTTONS;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] ps2_key = '0;
   logic [31:0] joy_usb = '0;
   logic [31:0] joy_ext = '0;
   logic [1:0]  ext_ena = '0;
   logic [2:0]  autofire_mask = '0;
   logic [31:0] joy_out;
   logic        pause;

   arcade_input #(
      .PLAYERS(PLAYERS), .BUTTONS(BUTTONS),
      .AUTOFIRE_DIV(AFD), .COIN_PULSE(COIN)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key),
      .joy_usb(joy_usb), .joy_ext(joy_ext), .ext_ena(ext_ena),
      .autofire_mask(autofire_mask), .joy_out(joy_out), .pause(pause)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int coin_hi = 0;

   // ---------------- reference model state ----------------
   logic [15:0] m_key[2], m_s1[2], m_prev[2];
   bit          m_phase[2][3];
   int          m_coin[2];
   logic        m_pause;
   logic [31:0] m_out;
   int          m_edge;
   bit          ev_now;
   logic [7:0]  ev_code;
   bit          ev_press;
   logic [7:0]  kcode[2][16];
   logic [7:0]  codes[20];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic init_table();
      for (int p = 0; p < 2; p++)
         for (int b = 0; b < 16; b++) kcode[p][b] = 8'h00;
      kcode[0][3] = 8'h75; kcode[0][2] = 8'h72; kcode[0][1] = 8'h6B; kcode[0][0] = 8'h74;
      kcode[0][4] = 8'h14; kcode[0][5] = 8'h11; kcode[0][6] = 8'h29;
      kcode[0][START_BIT] = 8'h16; kcode[0][COIN_BIT] = 8'h2E; kcode[0][PAUSE_BIT] = 8'h4D;
      kcode[1][3] = 8'h2D; kcode[1][2] = 8'h2B; kcode[1][1] = 8'h23; kcode[1][0] = 8'h34;
      kcode[1][4] = 8'h1C; kcode[1][5] = 8'h1B; kcode[1][6] = 8'h15;
      kcode[1][START_BIT] = 8'h1E; kcode[1][COIN_BIT] = 8'h36;
      codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h4D,
                8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36, 8'h5A};
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         m_key[p] = '0; m_s1[p] = '0; m_prev[p] = '0; m_coin[p] = 0;
         for (int b = 0; b < 3; b++) m_phase[p][b] = 1'b0;
      end
      m_pause = 1'b0; m_out = '0; m_edge = 0; ev_now = 1'b0;
   endtask

   // One clock edge of the specified behaviour.
   task automatic model_edge();
      logic [31:0] o;
      logic [15:0] rise, src;
      bit          tick, any_pause, held;
      int          k;
      m_edge++;
      tick = (m_edge % AFD) == 0;
      o = '0;
      any_pause = 1'b0;
      for (int p = 0; p < 2; p++) begin
         // the first capture after reset is never an edge
         rise = (m_edge >= 3) ? (m_s1[p] & ~m_prev[p]) : 16'h0;
         if (m_s1[p][1:0] != 2'b11) o[p*16 +: 2] = m_s1[p][1:0];
         if (m_s1[p][3:2] != 2'b11) o[p*16+2 +: 2] = m_s1[p][3:2];
         for (int b = 0; b < 3; b++) begin
            held = m_s1[p][4+b];
            if (rise[4+b]) m_phase[p][b] = 1'b1;
            else if (held && tick) m_phase[p][b] = !m_phase[p][b];
            o[p*16+4+b] = held && (!autofire_mask[b] || m_phase[p][b]);
         end
         o[p*16+START_BIT] = m_s1[p][START_BIT];
         if (m_coin[p] > 0) m_coin[p]--;
         else if (rise[COIN_BIT]) m_coin[p] = COIN;
         o[p*16+COIN_BIT] = (m_coin[p] > 0);
         if (rise[PAUSE_BIT]) any_pause = 1'b1;
      end
      if (any_pause) m_pause = ~m_pause;
      m_out = o;
      k = 0;
      for (int p = 0; p < 2; p++) begin
         m_prev[p] = m_s1[p];
         if (ext_ena[p]) src = joy_ext[p*16 +: 16];
         else begin
            src = joy_usb[k*16 +: 16];
            k++;
         end
         m_s1[p] = (src & 16'h03FF) | m_key[p];
      end
      if (ev_now) begin
         for (int p = 0; p < 2; p++)
            for (int b = 0; b < 16; b++)
               if (kcode[p][b] != 8'h00 && kcode[p][b] == ev_code) m_key[p][b] = ev_press;
         ev_now = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("joy_out", joy_out, m_out);
      check("pause", {31'b0, pause}, {31'b0, m_pause});
      coin_hi += int'(joy_out[COIN_BIT]);
   endtask

   task automatic ps2_ev(input logic [7:0] code, input bit pressed);
      ps2_key  = {~ps2_key[10], pressed, 1'($urandom), code};
      ev_now   = 1'b1;
      ev_code  = code;
      ev_press = pressed;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_joy_out", joy_out, 32'h0);
      check("rst_pause", {31'b0, pause}, 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic clear_inputs();
      joy_usb = '0; joy_ext = '0; ext_ena = '0; autofire_mask = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit af[24], ab[24];
      int f, cnt, r, bn;
      init_table();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_joy", joy_out, 32'h0);
      check("reset_pause", {31'b0, pause}, 32'h0);
      reset_n = 1'b1;
      repeat (3) step();

      // allocation: P0 on external slot 0, P1 on USB pad 0
      ext_ena = 2'b01; joy_usb[0] = 1'b1; joy_ext[3] = 1'b1;
      step(); step();
      check("alloc_p0", {16'h0, joy_out[15:0]}, 32'h0008);
      check("alloc_p1", {16'h0, joy_out[31:16]}, 32'h0001);
      clear_inputs(); repeat (3) step();

      // SOCD
      joy_usb[3:0] = 4'b1011; step(); step();
      check("socd_lru", {28'h0, joy_out[3:0]}, 32'h8);
      joy_usb[0] = 1'b0; step(); step();
      check("socd_lu", {28'h0, joy_out[3:0]}, 32'hA);
      clear_inputs(); repeat (3) step();

      // autofire on button 0, button 1 steady
      autofire_mask = 3'b001; joy_usb[5:4] = 2'b11;
      for (int i = 0; i < 24; i++) begin
         step();
         af[i] = joy_out[4];
         ab[i] = joy_out[5];
      end
      check("af_start", {31'b0, af[1]}, 32'h1);
      f = -1;
      for (int i = 2; i < 24; i++) if (!af[i] && f < 0) f = i;
      check("af_first_fall", (f >= 2 && f <= 5) ? 32'h1 : 32'h0, 32'h1);
      if (f >= 2 && f <= 5)
         for (int j = 0; j < 12; j++)
            check("af_wave", {31'b0, af[f+j]}, ((j / 4) % 2 == 0) ? 32'h0 : 32'h1);
      cnt = 0;
      for (int i = 1; i < 24; i++) cnt += int'(ab[i]);
      check("af_steady", cnt, 23);
      clear_inputs(); repeat (3) step();

      // coin: held, double press during pulse, second pulse
      joy_usb[COIN_BIT] = 1'b1; coin_hi = 0;
      repeat (50) step();
      check("coin_hold", coin_hi, 5);
      joy_usb[COIN_BIT] = 1'b0; step(); step();
      coin_hi = 0;
      joy_usb[COIN_BIT] = 1'b1; step();
      joy_usb[COIN_BIT] = 1'b0; step();
      joy_usb[COIN_BIT] = 1'b1; step();
      joy_usb[COIN_BIT] = 1'b0;
      repeat (12) step();
      check("coin_retrig", coin_hi, 5);
      coin_hi = 0; joy_usb[COIN_BIT] = 1'b1;
      repeat (10) step();
      check("coin_second", coin_hi, 5);
      clear_inputs(); repeat (3) step();

      // keyboard pause and simultaneous USB pause
      ps2_ev(8'h4D, 1'b1); step(); step();
      check("kpause_t2", {31'b0, pause}, 32'h0);
      step();
      check("kpause_t3", {31'b0, pause}, 32'h1);
      ps2_ev(8'h4D, 1'b0); repeat (4) step();
      check("kpause_release", {31'b0, pause}, 32'h1);
      joy_usb[PAUSE_BIT] = 1'b1; joy_usb[16+PAUSE_BIT] = 1'b1;
      step(); step();
      check("dual_pause", {31'b0, pause}, 32'h0);
      repeat (3) step();
      check("dual_pause_hold", {31'b0, pause}, 32'h0);
      clear_inputs(); repeat (3) step();

      // reset mid coin pulse with pause set
      joy_usb[PAUSE_BIT] = 1'b1; step(); step();
      check("pause_set", {31'b0, pause}, 32'h1);
      joy_usb[PAUSE_BIT] = 1'b0; joy_usb[COIN_BIT] = 1'b1;
      step(); step(); step();
      check("coin_mid", {31'b0, joy_out[COIN_BIT]}, 32'h1);
      do_reset();
      coin_hi = 0; repeat (10) step();
      check("coin_after_reset", coin_hi, 0);
      joy_usb[COIN_BIT] = 1'b0; step(); step();
      joy_usb[COIN_BIT] = 1'b1; coin_hi = 0; repeat (10) step();
      check("coin_repress", coin_hi, 5);
      clear_inputs(); repeat (3) step();

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(3) == 0) begin
            r  = int'($urandom_range(3));
            bn = int'($urandom_range(15));
            if (r < 2) joy_usb[r*16+bn] = ~joy_usb[r*16+bn];
            else       joy_ext[(r-2)*16+bn] = ~joy_ext[(r-2)*16+bn];
         end
         if ($urandom_range(63) == 0) ext_ena = 2'($urandom);
         if ($urandom_range(63) == 0) autofire_mask = 3'($urandom);
         if ($urandom_range(15) == 0 && m_edge >= 1)
            ps2_ev(codes[$urandom_range(19)], 1'($urandom));
         if (c == 700) do_reset();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/arcade_input.md
# arcade_input

Parametrised input front end for arcade cores. It replaces the per-core keyboard, joystick and DB9/DB15 merge logic with one registered block. It serves up to four players with a configurable button count, and adds:
- ordered USB-to-player allocation around external (UserIO) pads;
- SOCD cleaning;
- per-button autofire;
- a fixed-length coin pulse;
- a latched pause toggle.

It sits between `hps_io` / joystick adapters and the game core, in `clk_sys`.

## Interface
- `PLAYERS`, 2, player count (1–4).
- `BUTTONS`, 3, fire buttons per player (1–9).
- `AUTOFIRE_DIV`, 4_000_000, clock cycles per autofire half-period (≥2).
- `COIN_PULSE`, 1_000_000, coin output high time in cycles (≥1).

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_key` in 11: [10] toggle on each event, [9] pressed, [7:0] scan code.
- `joy_usb` in PLAYERS*16: USB pads in index order. Per-pad layout: [0]R [1]L [2]D [3]U [4+b] button b, [4+BUTTONS] start, [5+BUTTONS] coin, [6+BUTTONS] pause.
- `joy_ext` in PLAYERS*16: external pads, same layout, one slot per player.
- `ext_ena` in PLAYERS: player p takes `joy_ext` slot p instead of a USB pad.
- `autofire_mask` in BUTTONS: buttons with autofire enabled (shared by all players).
- `joy_out` out PLAYERS*16: processed controls, same layout. Pause bit and all bits above 5+BUTTONS are always 0.
- `pause` out 1: latched pause state.

## Operation
- **Keyboard.** A change of `ps2_key[10]` versus its registered copy writes `ps2_key[9]` into the matching key register. Bit 8 is ignored.
  - P0: up 75, down 72, left 6B, right 74, buttons 0..2 = 14/11/29, start 16, coin 2E, pause 4D.
  - P1: up 2D, down 2B, left 23, right 34, buttons 0..2 = 1C/1B/15, start 1E, coin 36.
  - Keys for buttons ≥ BUTTONS or players ≥ PLAYERS are ignored.
- **Source allocation.**
  - Player p with `ext_ena[p]`=1 uses `joy_ext[p]`.
  - Otherwise it uses USB pad k, where k = number of players q<p with `ext_ena[q]`=0.
  - Keyboard bits are OR'd in.
- **Stage 1 register (S1)** holds the merged raw vector per player.
- **Stage 2 logic, from S1:**
  - SOCD: L&R both set → both 0. U&D both set → both 0. Axes are independent.
  - Autofire:
    - A free-running tick fires every AUTOFIRE_DIV cycles.
    - Each player/button has a phase bit. It is set to 1 on the button's S1 rising edge, and toggles on each tick while the button is held.
    - Output = held & (mask[b] ? phase : 1).
    - A press on the same cycle as a tick starts at phase 1; the tick is ignored for that button.
  - Coin:
    - An S1 rising edge with the pulse counter idle loads COIN_PULSE; output is high while the counter is nonzero.
    - Edges during an active pulse are ignored.
    - Holding coin longer than the pulse gives exactly one pulse.
    - There is no retrigger until coin is released and pressed again.
  - Start passes straight through.
- **Pause.** An S1 rising edge of any player's pause bit (including the keyboard P) toggles `pause`. Simultaneous edges from several players toggle it once.
- **`autofire_mask` changes** take effect at the next stage 2 evaluation. Phase bits are not reset.

## Timing
- `reset_n` low, asynchronously:
  - `joy_out`=0, `pause`=0;
  - key registers, S1, phase bits, coin and tick counters = 0;
  - the toggle copy takes `ps2_key[10]` on the first clock after release, so no spurious event occurs.
- Latency, pad input → `joy_out`: 2 cycles.
- Latency, keyboard event → `joy_out`: 3 cycles.
- Latency, pause edge → `pause`: 2 cycles (keyboard: 3).
- The coin pulse is high for exactly COIN_PULSE consecutive cycles.
- The autofire output is high for AUTOFIRE_DIV cycles (±1 on the first half-period) and low for AUTOFIRE_DIV cycles.
- Reset asserted mid-pulse or mid-autofire clears all state immediately. The next press behaves as a first press.
- Changing `ext_ena` re-allocates pads from the next S1 capture. No state is reset, so edges may be seen.

## Test plan
- **Allocation.** PLAYERS=2, `ext_ena`=01, `joy_usb` pad0 R=1, `joy_ext` slot0 U=1 → 2 cycles later P0=U (bit3), P1=R (bit0).
- **SOCD.** P0 L+R+U held → `joy_out`[3:0]=4'b1000; release R → 4'b1010.
- **Autofire.** AUTOFIRE_DIV=4, mask=001, hold P0 button0 for 20 cycles → square wave, 4 high / 4 low, starting high; button1 held → steady 1.
- **Coin.** COIN_PULSE=5:
  - coin held 50 cycles → exactly 5 high cycles;
  - two presses 2 cycles apart while pulse active → one pulse;
  - release and press again after the pulse → second pulse.
- **Keyboard and pause.**
  - ps2 events 4D pressed, then 4D released → `pause` 0→1 three cycles after press, unchanged on release.
  - USB pause edges from P0 and P1 on the same cycle → single toggle.
- **Reset.** Assert `reset_n`=0 mid coin pulse with `pause`=1 → all outputs 0 asynchronously; after release, held coin produces no pulse until re-pressed.
